router_port_rx: RTL and testbench

- Parametrised single-port serial receiver for the router's per-port serial packet protocol: frame_n, valid_n and a 1-bit din.
- Detects the frame start, collects the LSB-first destination address, skips the pad field, then deserialises payload bits into DATA_W-wide words on a valid/ready stream.
- One instance per input port; instances sit in front of the switch fabric.
- Generalises the fixed 4-bit-address, byte-payload, 16-port arrangement to configurable address width, word width and pad length.
- Adds framing-error and overflow detection.

---
 rtl/router_pkg.sv | 21 ++
 rtl/router_out_reg.sv | 66 ++++++
 rtl/router_port_rx.sv | 226 ++++++++++++++++++++++
 tb/tb_router_port_rx.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared types and defaults for the router serial receive port.
package router_pkg;

  localparam int ROUTER_ADDR_W     = 4;
  localparam int ROUTER_DATA_W     = 8;
  localparam int ROUTER_PAD_CYCLES = 5;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ADDR = 3'd1,
    PAD  = 3'd2,
    DATA = 3'd3,
    DROP = 3'd4
  } rx_state_e;

  // Saturating increment for the 16-bit event counters
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/router_out_reg.sv
// One-deep valid/ready holding register for deserialised words.
// A push while the held word is stalled is dropped and flagged as overflow;
// a push in the same cycle as an accept simply reloads the register.
module router_out_reg import router_pkg::*; #(
  parameter int DATA_W = ROUTER_DATA_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              push_last_i,
  input  logic              ready_i,
  output logic              blocked_o,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic              last_o,
  output logic              ovf_o
);

  logic              valid_d, valid_q;
  logic [DATA_W-1:0] data_d, data_q;
  logic              last_d, last_q;
  logic              ovf_d, ovf_q;

  // Held word that is not being accepted this cycle
  assign blocked_o = valid_q && !ready_i;

  // Drain on accept, reload on push unless the held word is stuck
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    last_d  = last_q;
    ovf_d   = 1'b0;
    if (valid_q && ready_i) valid_d = 1'b0;
    if (push_i) begin
      if (blocked_o) begin
        ovf_d = 1'b1;
      end else begin
        valid_d = 1'b1;
        data_d  = push_data_i;
        last_d  = push_last_i;
      end
    end
  end

  // Holding register and overflow pulse
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
      ovf_q   <= ovf_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign last_o  = last_q;
  assign ovf_o   = ovf_q;

endmodule

// File: rtl/router_port_rx.sv
// Per-port serial packet receiver: frame detect, LSB-first destination
// address, fixed pad field, then payload deserialised into DATA_W words.
// Optional statistics counters are built when ROUTER_PORT_RX_STATS_EN is
// defined; the default build has no counter ports.
module router_port_rx import router_pkg::*; #(
  parameter int ADDR_W     = ROUTER_ADDR_W,
  parameter int DATA_W     = ROUTER_DATA_W,
  parameter int PAD_CYCLES = ROUTER_PAD_CYCLES
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              din_i,
  input  logic              frame_n_i,
  input  logic              valid_n_i,
  output logic              pkt_start_o,
  output logic [ADDR_W-1:0] dst_addr_o,
  output logic [DATA_W-1:0] out_data_o,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic              out_last_o,
  output logic              err_frag_o,
  output logic              err_ovf_o,
  output logic              busy_o
`ifdef ROUTER_PORT_RX_STATS_EN
  ,
  output logic [15:0]       pkt_cnt_o,
  output logic [15:0]       frag_cnt_o,
  output logic [15:0]       ovf_cnt_o
`endif
);

  localparam int AC_W = (ADDR_W > 1)     ? $clog2(ADDR_W)     : 1;
  localparam int DC_W = (DATA_W > 1)     ? $clog2(DATA_W)     : 1;
  localparam int PC_W = (PAD_CYCLES > 1) ? $clog2(PAD_CYCLES) : 1;

  localparam logic [AC_W-1:0] ADDR_LAST = AC_W'(ADDR_W - 1);
  localparam logic [DC_W-1:0] DATA_LAST = DC_W'(DATA_W - 1);
  localparam logic [PC_W-1:0] PAD_LAST  = PC_W'(PAD_CYCLES - 1);

  rx_state_e         state_d, state_q;
  logic              frame_q;
  logic [AC_W-1:0]   addr_cnt_d, addr_cnt_q;
  logic [PC_W-1:0]   pad_cnt_d, pad_cnt_q;
  logic [DC_W-1:0]   bit_cnt_d, bit_cnt_q;
  logic [ADDR_W-1:0] addr_sh_d, addr_sh_q;
  logic [ADDR_W-1:0] dst_addr_d, dst_addr_q;
  logic [DATA_W-1:0] word_d, word_q;
  logic              pkt_start_d, pkt_start_q;
  logic              err_frag_d, err_frag_q;
  logic              addr_done;
  logic              push;
  logic              out_blocked;

  // Receive FSM next-state: address/pad/data sequencing and framing checks
  always_comb begin
    state_d     = state_q;
    addr_cnt_d  = addr_cnt_q;
    pad_cnt_d   = pad_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    addr_sh_d   = addr_sh_q;
    dst_addr_d  = dst_addr_q;
    word_d      = word_q;
    pkt_start_d = 1'b0;
    err_frag_d  = 1'b0;
    addr_done   = 1'b0;
    push        = 1'b0;

    case (state_q)
      IDLE: begin
        // Start only on a seen falling edge, so a frame already low out of
        // reset is ignored until it has gone high once.
        if (!frame_n_i && frame_q) begin
          addr_sh_d    = '0;
          addr_sh_d[0] = din_i;
          addr_cnt_d   = AC_W'(1);
          if (ADDR_W == 1) addr_done = 1'b1;
          else             state_d   = ADDR;
        end
      end
      ADDR: begin
        if (frame_n_i) begin
          err_frag_d = 1'b1;
          state_d    = IDLE;
        end else begin
          addr_sh_d[addr_cnt_q] = din_i;
          addr_cnt_d            = addr_cnt_q + 1'b1;
          if (addr_cnt_q == ADDR_LAST) addr_done = 1'b1;
        end
      end
      PAD: begin
        if (frame_n_i) begin
          err_frag_d = 1'b1;
          state_d    = IDLE;
        end else if (!valid_n_i) begin
          err_frag_d = 1'b1;
          state_d    = DROP;
        end else if (pad_cnt_q == PAD_LAST) begin
          state_d   = DATA;
          bit_cnt_d = '0;
        end else begin
          pad_cnt_d = pad_cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (!valid_n_i) begin
          word_d[bit_cnt_q] = din_i;
          if (bit_cnt_q == DATA_LAST) begin
            push      = 1'b1;
            bit_cnt_d = '0;
            // Overflow drops the rest of the frame; if the frame ends on
            // this very bit there is nothing left to drop.
            if (frame_n_i)        state_d = IDLE;
            else if (out_blocked) state_d = DROP;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (frame_n_i) begin
              err_frag_d = 1'b1;
              state_d    = IDLE;
            end
          end
        end else if (frame_n_i) begin
          err_frag_d = 1'b1;
          state_d    = IDLE;
        end
      end
      DROP: begin
        if (frame_n_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Address complete: publish it and enter the pad field
    if (addr_done) begin
      dst_addr_d  = addr_sh_d;
      pkt_start_d = 1'b1;
      if (PAD_CYCLES == 0) begin
        state_d   = DATA;
        bit_cnt_d = '0;
      end else begin
        state_d   = PAD;
        pad_cnt_d = '0;
      end
    end
  end

  // Receive FSM state, counters and registered pulses
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      frame_q     <= 1'b0;
      addr_cnt_q  <= '0;
      pad_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      addr_sh_q   <= '0;
      dst_addr_q  <= '0;
      word_q      <= '0;
      pkt_start_q <= 1'b0;
      err_frag_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      frame_q     <= frame_n_i;
      addr_cnt_q  <= addr_cnt_d;
      pad_cnt_q   <= pad_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      addr_sh_q   <= addr_sh_d;
      dst_addr_q  <= dst_addr_d;
      word_q      <= word_d;
      pkt_start_q <= pkt_start_d;
      err_frag_q  <= err_frag_d;
    end
  end

  router_out_reg #(.DATA_W(DATA_W)) u_out_reg (
    .clock       (clock),
    .reset       (reset),
    .push_i      (push),
    .push_data_i (word_d),
    .push_last_i (frame_n_i),
    .ready_i     (out_ready_i),
    .blocked_o   (out_blocked),
    .valid_o     (out_valid_o),
    .data_o      (out_data_o),
    .last_o      (out_last_o),
    .ovf_o       (err_ovf_o)
  );

  assign pkt_start_o = pkt_start_q;
  assign dst_addr_o  = dst_addr_q;
  assign err_frag_o  = err_frag_q;
  assign busy_o      = (state_q != IDLE);

`ifdef ROUTER_PORT_RX_STATS_EN
  logic        pkt_done, ovf_evt;
  logic [15:0] pkt_cnt_d, pkt_cnt_q;
  logic [15:0] frag_cnt_d, frag_cnt_q;
  logic [15:0] ovf_cnt_d, ovf_cnt_q;

  assign pkt_done = push && frame_n_i && !out_blocked;
  assign ovf_evt  = push && out_blocked;

  // Saturating event counters
  always_comb begin
    pkt_cnt_d  = pkt_done   ? sat_inc16(pkt_cnt_q)  : pkt_cnt_q;
    frag_cnt_d = err_frag_d ? sat_inc16(frag_cnt_q) : frag_cnt_q;
    ovf_cnt_d  = ovf_evt    ? sat_inc16(ovf_cnt_q)  : ovf_cnt_q;
  end

  // Counter registers
  always_ff @(posedge clock) begin
    if (reset) begin
      pkt_cnt_q  <= '0;
      frag_cnt_q <= '0;
      ovf_cnt_q  <= '0;
    end else begin
      pkt_cnt_q  <= pkt_cnt_d;
      frag_cnt_q <= frag_cnt_d;
      ovf_cnt_q  <= ovf_cnt_d;
    end
  end

  assign pkt_cnt_o  = pkt_cnt_q;
  assign frag_cnt_o = frag_cnt_q;
  assign ovf_cnt_o  = ovf_cnt_q;
`endif

endmodule

// File: tb/tb_router_port_rx.sv
// Bench for router_port_rx: directed vector table, hand-written corner
// sequences and randomized packets checked against a packet-level model.
module tb_router_port_rx;

  localparam int AW = 4;
  localparam int DW = 8;
  localparam int PC = 5;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic          reset, din_i, frame_n_i, valid_n_i, out_ready_i;
  logic          pkt_start_o, out_valid_o, out_last_o, err_frag_o, err_ovf_o, busy_o;
  logic [AW-1:0] dst_addr_o;
  logic [DW-1:0] out_data_o;
`ifdef ROUTER_PORT_RX_STATS_EN
  logic [15:0]   pkt_cnt_o, frag_cnt_o, ovf_cnt_o;
`endif

  router_port_rx #(.ADDR_W(AW), .DATA_W(DW), .PAD_CYCLES(PC)) dut (
    .clock       (clock),
    .reset       (reset),
    .din_i       (din_i),
    .frame_n_i   (frame_n_i),
    .valid_n_i   (valid_n_i),
    .pkt_start_o (pkt_start_o),
    .dst_addr_o  (dst_addr_o),
    .out_data_o  (out_data_o),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_last_o  (out_last_o),
    .err_frag_o  (err_frag_o),
    .err_ovf_o   (err_ovf_o),
    .busy_o      (busy_o)
`ifdef ROUTER_PORT_RX_STATS_EN
    ,
    .pkt_cnt_o   (pkt_cnt_o),
    .frag_cnt_o  (frag_cnt_o),
    .ovf_cnt_o   (ovf_cnt_o)
`endif
  );

  typedef struct { int cyc; logic [AW-1:0] a; } aev_t;
  typedef struct { int cyc; logic [DW-1:0] d; logic last; } wev_t;
  typedef struct {
    logic [AW-1:0] addr;
    int            nw;
    logic [DW-1:0] w0, w1, w2;
    int            stall_bit, stall_len, frag_bits;
    int            exp_nw;
    logic [DW-1:0] e0, e1, e2;
    logic [2:0]    e_last;
    int            exp_frag;
  } vec_t;

  int            checks = 0;
  int            failures = 0;
  int            cyc = 0;
  aev_t          got_a[$], exp_a[$];
  wev_t          got_w[$], exp_w[$];
  int            got_frag[$], got_ovf[$];
  int            a_rd, w_rd, f_rd, o_rd, exp_frag;
  int            word_end_cyc[$];
  int            addr_cyc;
  logic          busy_after;
  logic [DW-1:0] tx_words[$];
  vec_t          tv[6];

  // Observed events, stamped with the edge that produced them
  always @(negedge clock) begin
    if (!reset) begin
      if (pkt_start_o)                got_a.push_back('{cyc, dst_addr_o});
      if (out_valid_o && out_ready_i) got_w.push_back('{cyc, out_data_o, out_last_o});
      if (err_frag_o)                 got_frag.push_back(cyc);
      if (err_ovf_o)                  got_ovf.push_back(cyc);
    end
  end

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", nm, got, exp);
    end
  endtask

  task automatic tick(input logic f, input logic v, input logic d);
    frame_n_i = f; valid_n_i = v; din_i = d;
    @(posedge clock); #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b1, 1'b1, 1'b0);
  endtask

  task automatic sync_rd();
    a_rd = got_a.size(); w_rd = got_w.size();
    f_rd = got_frag.size(); o_rd = got_ovf.size();
    exp_a.delete(); exp_w.delete(); exp_frag = 0;
  endtask

  // Drive one packet from tx_words; frag_bits>0 ends the frame on that bit
  task automatic send_pkt(input logic [AW-1:0] addr, input int frag_bits,
                          input int stall_bit, input int stall_len, input bit rnd_stall);
    int nb;
    word_end_cyc.delete();
    for (int i = 0; i < AW; i++) tick(1'b0, 1'b1, addr[i]);
    addr_cyc = cyc;
    for (int i = 0; i < PC; i++) tick(1'b0, 1'b1, 1'($urandom_range(0, 1)));
    nb = tx_words.size() * DW;
    if (frag_bits > 0 && frag_bits < nb) nb = frag_bits;
    for (int k = 0; k < nb; k++) begin
      logic [DW-1:0] w;
      if (k == stall_bit) repeat (stall_len) tick(1'b0, 1'b1, 1'($urandom_range(0, 1)));
      if (rnd_stall && $urandom_range(0, 5) == 0)
        repeat ($urandom_range(1, 3)) tick(1'b0, 1'b1, 1'($urandom_range(0, 1)));
      w = tx_words[k / DW];
      tick((k == nb - 1), 1'b0, w[k % DW]);
      if (k % DW == DW - 1) word_end_cyc.push_back(cyc);
    end
    busy_after = busy_o;
  endtask

  // Packet-level reference: complete words pass through unchanged, last set
  // only when the frame ends on a word boundary, otherwise one fragment error
  task automatic model_pkt(input logic [AW-1:0] addr, input int frag_bits);
    int nb, nw;
    bit clean;
    nb = tx_words.size() * DW;
    if (frag_bits > 0 && frag_bits < nb) nb = frag_bits;
    nw = nb / DW;
    clean = (nb % DW) == 0;
    exp_a.push_back('{addr_cyc, addr});
    for (int i = 0; i < nw; i++)
      exp_w.push_back('{word_end_cyc[i], tx_words[i], logic'(clean && (i == nw - 1))});
    if (!clean) exp_frag++;
  endtask

  task automatic check_all(input string tag);
    int ng, nw;
    ng = got_a.size() - a_rd;
    chk({tag, " addr_count"}, ng, exp_a.size());
    for (int i = 0; i < exp_a.size() && i < ng; i++) begin
      chk({tag, " dst_addr"}, int'(got_a[a_rd + i].a), int'(exp_a[i].a));
      chk({tag, " addr_cycle"}, got_a[a_rd + i].cyc, exp_a[i].cyc);
    end
    nw = got_w.size() - w_rd;
    chk({tag, " word_count"}, nw, exp_w.size());
    for (int i = 0; i < exp_w.size() && i < nw; i++) begin
      chk({tag, " word_data"}, int'(got_w[w_rd + i].d), int'(exp_w[i].d));
      chk({tag, " word_last"}, int'(got_w[w_rd + i].last), int'(exp_w[i].last));
      chk({tag, " word_cycle"}, got_w[w_rd + i].cyc, exp_w[i].cyc);
    end
    chk({tag, " frag_count"}, got_frag.size() - f_rd, exp_frag);
    chk({tag, " ovf_count"}, got_ovf.size() - o_rd, 0);
    sync_rd();
  endtask

  initial begin
    int lat, lat0;
    logic [DW-1:0] ew;
    logic [AW-1:0] ra;
    logic [DW-1:0] rw;

    //        addr   nw w0     w1     w2     stb sl fr exn e0     e1     e2     last    frag
    tv[0] = '{4'hA, 2, 8'h5A, 8'hC3, 8'h00, -1, 0, 0,  2, 8'h5A, 8'hC3, 8'h00, 3'b010, 0};
    tv[1] = '{4'hA, 2, 8'h5A, 8'hC3, 8'h00,  3, 3, 0,  2, 8'h5A, 8'hC3, 8'h00, 3'b010, 0};
    tv[2] = '{4'h3, 1, 8'h81, 8'h00, 8'h00, -1, 0, 0,  1, 8'h81, 8'h00, 8'h00, 3'b001, 0};
    tv[3] = '{4'hF, 3, 8'h11, 8'h22, 8'h33, 10, 1, 0,  3, 8'h11, 8'h22, 8'h33, 3'b100, 0};
    tv[4] = '{4'h5, 2, 8'h12, 8'h34, 8'h00, -1, 0, 5,  0, 8'h00, 8'h00, 8'h00, 3'b000, 1};
    tv[5] = '{4'h0, 2, 8'hAA, 8'h55, 8'h00, -1, 0, 12, 1, 8'hAA, 8'h00, 8'h00, 3'b000, 1};

    reset = 1'b1; din_i = 1'b0; frame_n_i = 1'b1; valid_n_i = 1'b1; out_ready_i = 1'b1;
    idle(3);
    reset = 1'b0;
    chk("rst pkt_start", int'(pkt_start_o), 0);
    chk("rst dst_addr",  int'(dst_addr_o), 0);
    chk("rst out_data",  int'(out_data_o), 0);
    chk("rst out_valid", int'(out_valid_o), 0);
    chk("rst out_last",  int'(out_last_o), 0);
    chk("rst err_frag",  int'(err_frag_o), 0);
    chk("rst err_ovf",   int'(err_ovf_o), 0);
    chk("rst busy",      int'(busy_o), 0);
    sync_rd();
    idle(2);

    // Directed vector table
    lat0 = -1;
    for (int i = 0; i < 6; i++) begin
      tx_words.delete();
      tx_words.push_back(tv[i].w0);
      if (tv[i].nw > 1) tx_words.push_back(tv[i].w1);
      if (tv[i].nw > 2) tx_words.push_back(tv[i].w2);
      send_pkt(tv[i].addr, tv[i].frag_bits, tv[i].stall_bit, tv[i].stall_len, 1'b0);
      exp_a.push_back('{addr_cyc, tv[i].addr});
      for (int j = 0; j < tv[i].exp_nw; j++) begin
        ew = (j == 0) ? tv[i].e0 : (j == 1) ? tv[i].e1 : tv[i].e2;
        exp_w.push_back('{word_end_cyc[j], ew, tv[i].e_last[j]});
      end
      exp_frag = tv[i].exp_frag;
      chk($sformatf("vec%0d busy_end", i), int'(busy_after), 0);
      idle(2);
      lat = -100;
      if (tv[i].exp_nw > 0 && got_w.size() - w_rd >= tv[i].exp_nw && got_a.size() > a_rd)
        lat = got_w[w_rd + tv[i].exp_nw - 1].cyc - got_a[a_rd].cyc;
      if (i == 0) lat0 = lat;
      if (i == 1) chk("vec1 stall_shift", lat, lat0 + 3);
      check_all($sformatf("vec%0d", i));
    end

    // Overflow: consumer stalled through a 3-word packet
    sync_rd();
    out_ready_i = 1'b0;
    tx_words.delete();
    tx_words.push_back(8'h11); tx_words.push_back(8'h22); tx_words.push_back(8'h33);
    send_pkt(4'h2, 0, -1, 0, 1'b0);
    tick(1'b1, 1'b1, 1'b0);
    chk("ovf pulses", got_ovf.size() - o_rd, 1);
    if (got_ovf.size() > o_rd) chk("ovf cycle", got_ovf[o_rd], word_end_cyc[1]);
    chk("ovf held_valid", int'(out_valid_o), 1);
    chk("ovf held_data", int'(out_data_o), 8'h11);
    chk("ovf busy_end", int'(busy_after), 0);
    chk("ovf no_accept", got_w.size() - w_rd, 0);
    out_ready_i = 1'b1;
    idle(3);
    chk("ovf drained_count", got_w.size() - w_rd, 1);
    if (got_w.size() > w_rd) begin
      chk("ovf drained_data", int'(got_w[w_rd].d), 8'h11);
      chk("ovf drained_last", int'(got_w[w_rd].last), 0);
    end
    chk("ovf frag_count", got_frag.size() - f_rd, 0);
    sync_rd();

    // Reset during DATA with frame still low; pending word is lost
    out_ready_i = 1'b0;
    ra = 4'h6; rw = 8'h9C;
    for (int i = 0; i < AW; i++) tick(1'b0, 1'b1, ra[i]);
    for (int i = 0; i < PC; i++) tick(1'b0, 1'b1, 1'b0);
    for (int k = 0; k < DW + 3; k++) tick(1'b0, 1'b0, rw[k % DW]);
    chk("rstmid pending_valid", int'(out_valid_o), 1);
    reset = 1'b1;
    tick(1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    chk("rstmid valid_lost", int'(out_valid_o), 0);
    chk("rstmid busy", int'(busy_o), 0);
    reset = 1'b0;
    out_ready_i = 1'b1;
    sync_rd();
    for (int i = 0; i < 12; i++) tick(1'b0, 1'(i % 2), 1'($urandom_range(0, 1)));
    chk("rstmid no_start", got_a.size() - a_rd, 0);
    chk("rstmid idle", int'(busy_o), 0);
    idle(1);
    tx_words.delete(); tx_words.push_back(8'h3C);
    send_pkt(4'h9, 0, -1, 0, 1'b0);
    model_pkt(4'h9, 0);
    idle(2);
    check_all("rstmid restart");

    // Randomized packets, back-to-back allowed, against the packet model
    for (int p = 0; p < 20; p++) begin
      logic [AW-1:0] a;
      int nw, fb;
      a = AW'($urandom_range(0, (1 << AW) - 1));
      nw = $urandom_range(1, 4);
      tx_words.delete();
      for (int j = 0; j < nw; j++) tx_words.push_back(DW'($urandom_range(0, 255)));
      fb = ($urandom_range(0, 3) == 0) ? $urandom_range(1, nw * DW - 1) : 0;
      send_pkt(a, fb, -1, 0, 1'b1);
      model_pkt(a, fb);
      idle($urandom_range(0, 2));
    end
    idle(3);
    check_all("rnd");

`ifdef ROUTER_PORT_RX_STATS_EN
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    idle(1);
    for (int p = 0; p < 4; p++) begin
      tx_words.delete();
      tx_words.push_back(DW'(8'h40 + p)); tx_words.push_back(8'h77);
      send_pkt(AW'(p), (p == 2) ? 5 : 0, -1, 0, 1'b0);
      idle(1);
    end
    idle(2);
    chk("stats pkt_cnt",  int'(pkt_cnt_o), 3);
    chk("stats frag_cnt", int'(frag_cnt_o), 1);
    chk("stats ovf_cnt",  int'(ovf_cnt_o), 0);
    sync_rd();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
